// File: rtl/contactor_sequencer_if.sv
// Signal bundle between the pack fault FSM / host side and the contactor sequencer.
// master drives the requests and feedback; slave (the sequencer) drives the coils and status.
interface contactor_sequencer_if;
  logic [1:0] fault_state;
  logic       shutdown_signal;
  logic       enable_req;
  logic       precharge_done;
  logic       aux_closed;
  logic       clear_latch;
  logic       main_contactor;
  logic       precharge_relay;
  logic [2:0] seq_state;
  logic       ready;
  logic       latched_fault;
  logic [1:0] retry_count;

  modport master (
    output fault_state, shutdown_signal, enable_req, precharge_done, aux_closed, clear_latch,
    input  main_contactor, precharge_relay, seq_state, ready, latched_fault, retry_count
  );

  modport slave (
    input  fault_state, shutdown_signal, enable_req, precharge_done, aux_closed, clear_latch,
    output main_contactor, precharge_relay, seq_state, ready, latched_fault, retry_count
  );
endinterface

// File: rtl/contactor_sequencer.sv
// Timed precharge/close/open sequencer for the main contactor and precharge relay,
// with aux-contact motion checks, fault latching, retry counting and weld lockout.
module contactor_sequencer #(
  parameter int unsigned PRECHARGE_CYCLES  = 100,
  parameter int unsigned WELD_CHECK_CYCLES = 10,
  parameter int unsigned COOLDOWN_CYCLES   = 50,
  parameter int unsigned RETRY_LIMIT       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  contactor_sequencer_if.slave  bus
);

  localparam int unsigned MAX_PW  = (PRECHARGE_CYCLES > WELD_CHECK_CYCLES) ? PRECHARGE_CYCLES
                                                                            : WELD_CHECK_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_PW > COOLDOWN_CYCLES) ? MAX_PW : COOLDOWN_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRECHARGE_CYCLES - 1);
  localparam logic [CW-1:0] WELD_LAST = CW'(WELD_CHECK_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    S_OPEN      = 3'd0,
    S_PRECHARGE = 3'd1,
    S_CLOSING   = 3'd2,
    S_CLOSED    = 3'd3,
    S_OPENING   = 3'd4,
    S_COOLDOWN  = 3'd5,
    S_LOCKOUT   = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] dwell;
  logic [1:0]    retry_q, retry_nx;
  logic          latch_q, latch_nx;
  logic          trip, clear_ok, failed;

  always_comb begin
    trip     = bus.shutdown_signal | bus.fault_state[1];
    clear_ok = bus.clear_latch && (bus.fault_state == 2'b00);
    state_nx = state;
    latch_nx = latch_q;
    retry_nx = retry_q;
    failed   = 1'b0;

    case (state)
      S_OPEN: begin
        if (clear_ok)
          latch_nx = 1'b0;
        else if (bus.enable_req && (bus.fault_state == 2'b00) && !latch_q && !trip)
          state_nx = S_PRECHARGE;
      end
      S_PRECHARGE: begin
        if (trip) begin
          state_nx = S_OPENING;
          latch_nx = 1'b1;
        end else if (bus.precharge_done) begin
          state_nx = S_CLOSING;
        end else if (dwell == PRE_LAST) begin
          state_nx = S_OPENING;
          failed   = 1'b1;
        end else if (!bus.enable_req) begin
          state_nx = S_OPENING;
        end
      end
      S_CLOSING: begin
        if (trip) begin
          state_nx = S_OPENING;
          latch_nx = 1'b1;
        end else if (bus.aux_closed) begin
          state_nx = S_CLOSED;
          retry_nx = '0;
        end else if (dwell == WELD_LAST) begin
          state_nx = S_OPENING;
          failed   = 1'b1;
        end
      end
      S_CLOSED: begin
        if (trip) begin
          state_nx = S_OPENING;
          latch_nx = 1'b1;
        end else if (!bus.enable_req) begin
          state_nx = S_OPENING;
        end else if (!bus.aux_closed) begin
          state_nx = S_OPENING;
          latch_nx = 1'b1;
          failed   = 1'b1;
        end
      end
      S_OPENING: begin
        if (!bus.aux_closed)
          state_nx = S_COOLDOWN;
        else if (dwell == WELD_LAST)
          state_nx = S_LOCKOUT;
      end
      S_COOLDOWN: begin
        if (dwell == COOL_LAST)
          state_nx = (retry_q == RETRY_MAX) ? S_LOCKOUT : S_OPEN;
      end
      S_LOCKOUT: begin
        if (clear_ok) begin
          state_nx = S_OPEN;
          retry_nx = '0;
          latch_nx = 1'b0;
        end
      end
      default: state_nx = S_OPEN;
    endcase

    if (failed && (retry_nx != 2'd3))
      retry_nx = retry_nx + 2'd1;
  end

  // Coil drives are registered from the next state so they change on the same edge as seq_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= S_OPEN;
      dwell               <= '0;
      retry_q             <= '0;
      latch_q             <= 1'b0;
      bus.main_contactor  <= 1'b0;
      bus.precharge_relay <= 1'b0;
      bus.ready           <= 1'b0;
    end else begin
      state               <= state_nx;
      dwell               <= (state_nx != state) ? '0 : ((dwell == '1) ? dwell : dwell + 1'b1);
      retry_q             <= retry_nx;
      latch_q             <= latch_nx;
      bus.main_contactor  <= (state_nx == S_CLOSING) || (state_nx == S_CLOSED);
      bus.precharge_relay <= (state_nx == S_PRECHARGE) || (state_nx == S_CLOSING);
      bus.ready           <= (state_nx == S_CLOSED);
    end
  end

  assign bus.seq_state     = state;
  assign bus.latched_fault = latch_q;
  assign bus.retry_count   = retry_q;

endmodule

// File: tb/tb_contactor_sequencer.sv
// Scoreboard bench for contactor_sequencer: directed test-plan scenarios followed by
// randomized traffic, each cycle's expected outputs queued by a reference model.
module tb_contactor_sequencer;

  localparam int P = 100;
  localparam int W = 10;
  localparam int C = 50;
  localparam int R = 3;

  localparam int OPEN = 0, PRECHARGE = 1, CLOSING = 2, CLOSED = 3;
  localparam int OPENING = 4, COOLDOWN = 5, LOCKOUT = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  contactor_sequencer_if bus ();

  contactor_sequencer #(
    .PRECHARGE_CYCLES (P),
    .WELD_CHECK_CYCLES(W),
    .COOLDOWN_CYCLES  (C),
    .RETRY_LIMIT      (R)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int st;
    int main;
    int pre;
    int rdy;
    int lat;
    int rc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // reference model: phase, cycles already spent in it, failed attempts, latch
  int m_st = OPEN;
  int m_spent = 0;
  int m_retry = 0;
  int m_lat = 0;

  logic [1:0] i_fs = 2'b00;
  logic i_sd = 0, i_en = 0, i_pd = 0, i_aux = 0, i_clr = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.st   = m_st;
    e.main = (m_st == CLOSING || m_st == CLOSED) ? 1 : 0;
    e.pre  = (m_st == PRECHARGE || m_st == CLOSING) ? 1 : 0;
    e.rdy  = (m_st == CLOSED) ? 1 : 0;
    e.lat  = m_lat;
    e.rc   = m_retry;
    return e;
  endfunction

  task automatic model_reset();
    m_st = OPEN; m_spent = 0; m_retry = 0; m_lat = 0;
  endtask

  task automatic model_step(input logic [1:0] fs, input bit sd, en, pd, aux, clr);
    bit trip  = sd || (fs >= 2);
    bit clean = (fs == 0);
    int nxt   = m_st;
    bit fail  = 0;
    int now   = m_spent + 1;  // this cycle is the now-th one in the phase
    if (m_st == OPEN) begin
      if (clr && clean) m_lat = 0;
      else if (en && clean && m_lat == 0 && !trip) nxt = PRECHARGE;
    end else if (m_st == PRECHARGE) begin
      if (trip) begin nxt = OPENING; m_lat = 1; end
      else if (pd) nxt = CLOSING;
      else if (now == P) begin nxt = OPENING; fail = 1; end
      else if (!en) nxt = OPENING;
    end else if (m_st == CLOSING) begin
      if (trip) begin nxt = OPENING; m_lat = 1; end
      else if (aux) begin nxt = CLOSED; m_retry = 0; end
      else if (now == W) begin nxt = OPENING; fail = 1; end
    end else if (m_st == CLOSED) begin
      if (trip) begin nxt = OPENING; m_lat = 1; end
      else if (!en) nxt = OPENING;
      else if (!aux) begin nxt = OPENING; m_lat = 1; fail = 1; end
    end else if (m_st == OPENING) begin
      if (!aux) nxt = COOLDOWN;
      else if (now == W) nxt = LOCKOUT;
    end else if (m_st == COOLDOWN) begin
      if (now == C) nxt = (m_retry == R) ? LOCKOUT : OPEN;
    end else begin
      if (clr && clean) begin nxt = OPEN; m_retry = 0; m_lat = 0; end
    end
    if (fail) m_retry = (m_retry >= 3) ? 3 : m_retry + 1;
    m_spent = (nxt != m_st) ? 0 : m_spent + 1;
    m_st = nxt;
  endtask

  task automatic apply();
    bus.fault_state     = i_fs;
    bus.shutdown_signal = i_sd;
    bus.enable_req      = i_en;
    bus.precharge_done  = i_pd;
    bus.aux_closed      = i_aux;
    bus.clear_latch     = i_clr;
    model_step(i_fs, i_sd, i_en, i_pd, i_aux, i_clr);
    q.push_back(expect_now());
  endtask

  task automatic tick();
    @(negedge clk);
    apply();
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (m_st != target && n < budget);
    if (m_st != target) begin
      checks++;
      failures++;
      $display("FAIL %s: state %0d not reaching %0d within %0d cycles", name, m_st, target, budget);
    end
  endtask

  task automatic pulse_clear();
    i_clr = 1; tick(); i_clr = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(bus.seq_state), 0);
    chk({tag, "_main"}, int'(bus.main_contactor), 0);
    chk({tag, "_pre"}, int'(bus.precharge_relay), 0);
    chk({tag, "_ready"}, int'(bus.ready), 0);
    chk({tag, "_latched"}, int'(bus.latched_fault), 0);
    chk({tag, "_retry"}, int'(bus.retry_count), 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    q.push_back(expect_now());
    repeat (2) begin
      @(negedge clk);
      q.push_back(expect_now());
    end
    @(negedge clk);
    reset = 1'b1;
    apply();
  endtask

  // monitor: every cycle the DUT presents a new output set just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("seq_state", int'(bus.seq_state), e.st);
        chk("main_contactor", int'(bus.main_contactor), e.main);
        chk("precharge_relay", int'(bus.precharge_relay), e.pre);
        chk("ready", int'(bus.ready), e.rdy);
        chk("latched_fault", int'(bus.latched_fault), e.lat);
        chk("retry_count", int'(bus.retry_count), e.rc);
      end
    end
  end

  initial begin
    bit weld = 0;
    bit target;
    bus.fault_state = 2'b00; bus.shutdown_signal = 0; bus.enable_req = 0;
    bus.precharge_done = 0; bus.aux_closed = 0; bus.clear_latch = 0;
    model_reset();
    #3 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply();

    // normal close: precharge_done in the 20th precharge cycle, aux 3 cycles after main
    i_en = 1; tick();
    repeat (19) tick();
    i_pd = 1; tick(); i_pd = 0;
    tick(); tick();
    i_aux = 1;
    run_until(CLOSED, 5, "normal_close");
    repeat (5) tick();

    // shutdown pulse while closed, latched until cleared
    i_sd = 1; tick(); i_sd = 0;
    i_aux = 0;
    run_until(COOLDOWN, 5, "trip_opening");
    run_until(OPEN, C + 5, "trip_cooldown");
    repeat (10) tick();
    pulse_clear();
    run_until(PRECHARGE, 3, "reclose_after_clear");
    i_en = 0;
    run_until(OPEN, C + 10, "drop_in_precharge");

    // three precharge timeouts then lockout; clear under WARNING is ignored
    i_en = 1;
    run_until(LOCKOUT, 3 * (P + 1 + C) + 20, "timeout_lockout");
    repeat (5) tick();
    i_fs = 2'b01; pulse_clear(); i_fs = 2'b00;
    tick();
    i_en = 0;
    pulse_clear();
    repeat (3) tick();

    // weld: aux stays closed after the request drops
    i_en = 1; tick();
    i_pd = 1; tick(); i_pd = 0;
    tick();
    i_aux = 1;
    run_until(CLOSED, 3, "weld_close");
    repeat (3) tick();
    i_en = 0;
    run_until(LOCKOUT, W + 3, "weld_lockout");
    i_aux = 0;
    repeat (3) tick();
    pulse_clear();
    repeat (2) tick();

    // FAULT and precharge_done on the same edge
    i_en = 1; tick();
    repeat (5) tick();
    i_fs = 2'b10; i_pd = 1; tick();
    i_fs = 2'b00; i_pd = 0;
    run_until(OPEN, C + 10, "simultaneous");
    i_en = 0;
    pulse_clear();
    tick();

    // asynchronous reset mid-CLOSING, then no spontaneous request
    i_en = 1; tick();
    i_pd = 1; tick(); i_pd = 0;
    tick(); tick();
    i_en = 0;
    async_reset();
    repeat (5) tick();

    // randomized traffic with a simple contactor plant model
    for (int n = 0; n < 8000; n++) begin
      if ($urandom_range(0, 79) == 0) i_en = ~i_en;
      i_fs  = ($urandom_range(0, 199) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      i_sd  = ($urandom_range(0, 399) == 0);
      i_pd  = (m_st == PRECHARGE) && ($urandom_range(0, 39) == 0);
      i_clr = ($urandom_range(0, 29) == 0);
      if (!weld && $urandom_range(0, 2499) == 0) weld = 1;
      if (weld && m_st == LOCKOUT && $urandom_range(0, 9) == 0) weld = 0;
      target = (m_st == CLOSING || m_st == CLOSED);
      if (weld) i_aux = 1;
      else if (i_aux != target && $urandom_range(0, 2) == 0) i_aux = target;
      else if (target && $urandom_range(0, 599) == 0) i_aux = 0;
      tick();
    end

    i_en = 0; i_fs = 2'b00; i_sd = 0; i_pd = 0; i_clr = 0; i_aux = 0;
    repeat (3) tick();
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
